// File: rtl/div_round_pack_pkg.sv
// Shared FPU definitions: rounding modes, exponent biases and limits,
// special-value encodings, and the overflow result selection rule.
package div_round_pack_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_t;

    localparam int BIAS_D = 1023;
    localparam int BIAS_S = 127;
    localparam int EMAX_D = 2047;
    localparam int EMAX_S = 255;

    // Magnitudes only; the sign bit is supplied by the caller.
    localparam logic [63:0] INF_D  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] MAXF_D = 64'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [31:0] INF_S  = 32'h7F80_0000;
    localparam logic [31:0] MAXF_S = 32'h7F7F_FFFF;

    // On overflow, modes that round away from zero in the result's direction
    // (and round-to-nearest) saturate to infinity; the rest clamp to max-finite.
    function automatic logic overflow_to_inf(input rm_t rm, input logic sign);
        return (rm == RM_RNE) || ((rm == RM_RU) && !sign) || ((rm == RM_RD) && sign);
    endfunction

endpackage

// File: rtl/div_round_pack_if.sv
// Result interface between the divider core and its normalize/round/pack
// stage: a valid/ready input beat and a valid/ready packed result.
interface div_round_pack_if #(
    parameter int EW = 13
);
    import div_round_pack_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [56:0]       fq;
    logic              sign;
    logic [EW-1:0]     ediv;
    logic              db;
    rm_t               rm;

    logic              out_valid;
    logic              out_ready;
    logic [63:0]       res;
    logic              ovf;
    logic              unf;
    logic              inx;

    // Divider side: produces beats, consumes results.
    modport master (
        output in_valid, fq, sign, ediv, db, rm, out_ready,
        input  in_ready, out_valid, res, ovf, unf, inx
    );

    // Rounder side: consumes beats, produces results.
    modport slave (
        input  in_valid, fq, sign, ediv, db, rm, out_ready,
        output in_ready, out_valid, res, ovf, unf, inx
    );

endinterface

// File: rtl/div_round_pack_round_incr.sv
// Rounding increment decision shared by the divider and multiplier rounders.
// Takes the kept-significand LSB, guard and sticky bits and returns whether
// to add one ulp, plus the inexact indication.
module round_incr
    import div_round_pack_pkg::*;
(
    input  logic i_sig_lsb,
    input  logic i_g,
    input  logic i_st,
    input  rm_t  i_rm,
    input  logic i_sign,
    output logic o_inc,
    output logic o_inx
);

    // Select the increment for the active rounding mode.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves o_inc unassigned (no latch).
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE: o_inc = i_g & (i_st | i_sig_lsb);
            RM_RZ:  o_inc = 1'b0;
            RM_RU:  o_inc = ~i_sign & (i_g | i_st);
            RM_RD:  o_inc =  i_sign & (i_g | i_st);
        endcase
    end

    assign o_inx = i_g | i_st;

endmodule

// File: rtl/div_round_pack.sv
// Post-divide normalize / round / pack stage. Three registered stages
// (normalize, round, renormalize+range+pack) with a per-stage valid bit and
// a ready chain that lets a full pipeline accept and emit in the same cycle.
module div_round_pack
    import div_round_pack_pkg::*;
#(
    parameter int EW = 13
) (
    input logic             clk,
    input logic             rst,
    div_round_pack_if.slave bus
);

    localparam int         XW       = EW + 1;
    localparam logic [EW:0] E_BIAS_D = XW'(BIAS_D);
    localparam logic [EW:0] E_BIAS_S = XW'(BIAS_S);
    localparam logic [EW:0] E_MAX_D  = XW'(EMAX_D);
    localparam logic [EW:0] E_MAX_S  = XW'(EMAX_S);

    // Handshake
    logic        w_adv1, w_adv2, w_adv3;
    logic        r_s1_valid, r_s2_valid, r_s3_valid;

    // S1: normalized fraction (hidden bit is always 1 and not stored)
    logic [55:0] w_n;
    logic [EW:0] w_e1;
    logic [55:0] r_s1_n;
    logic [EW:0] r_s1_e;
    logic        r_s1_sign, r_s1_db;
    rm_t         r_s1_rm;

    // S2: rounded fraction and carry out of the significand
    logic        w_lsb, w_g, w_st, w_inc, w_inx;
    logic [51:0] w_frac;
    logic        w_carry;
    logic [51:0] r_s2_frac;
    logic        r_s2_carry;
    logic [EW:0] r_s2_e;
    logic        r_s2_sign, r_s2_db, r_s2_inx;
    rm_t         r_s2_rm;

    // S3: range check and pack
    logic [EW:0] w_e3;
    logic        w_ovf, w_unf;
    logic [63:0] w_res;
    logic [63:0] r_res;
    logic        r_ovf, r_unf, r_inx;

    // A stage moves when it is empty or its successor moves; out_ready closes the chain.
    assign w_adv3       = !r_s3_valid || bus.out_ready;
    assign w_adv2       = !r_s2_valid || w_adv3;
    assign w_adv1       = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1;

    // Normalize the quotient into [1,2) and form the biased exponent.
    always_comb begin
        w_n  = bus.fq[55:0];
        w_e1 = {bus.ediv[EW-1], bus.ediv} + (bus.db ? E_BIAS_D : E_BIAS_S);
        if (!bus.fq[56]) begin
            w_n  = {bus.fq[54:0], 1'b0};
            w_e1 = w_e1 - XW'(1);
        end
    end

    // Pick the kept LSB, guard and sticky for the working precision.
    always_comb begin
        if (r_s1_db) begin
            w_lsb = r_s1_n[4];
            w_g   = r_s1_n[3];
            w_st  = |r_s1_n[2:0];
        end else begin
            w_lsb = r_s1_n[33];
            w_g   = r_s1_n[32];
            w_st  = |r_s1_n[31:0];
        end
    end

    round_incr u_round_incr (
        .i_sig_lsb (w_lsb),
        .i_g       (w_g),
        .i_st      (w_st),
        .i_rm      (r_s1_rm),
        .i_sign    (r_s1_sign),
        .o_inc     (w_inc),
        .o_inx     (w_inx)
    );

    // Add the increment to the fraction; with the implicit leading 1, the
    // carry out of the fraction is exactly the significand overflow to 2.0.
    always_comb begin
        w_frac  = '0;
        w_carry = 1'b0;
        if (r_s1_db) begin
            {w_carry, w_frac} = {1'b0, r_s1_n[55:4]} + {52'b0, w_inc};
        end else begin
            {w_carry, w_frac[22:0]} = {1'b0, r_s1_n[55:33]} + {23'b0, w_inc};
        end
    end

    // Renormalize on carry, classify range and build the packed result.
    always_comb begin
        w_e3  = r_s2_e + {{EW{1'b0}}, r_s2_carry};
        w_ovf = !w_e3[EW] && (w_e3 >= (r_s2_db ? E_MAX_D : E_MAX_S));
        w_unf = w_e3[EW] || (w_e3 == '0);
        if (r_s2_db) begin
            w_res = {r_s2_sign, w_e3[10:0], r_s2_frac};
        end else begin
            w_res = {32'b0, r_s2_sign, w_e3[7:0], r_s2_frac[22:0]};
        end
        if (w_ovf) begin
            if (overflow_to_inf(r_s2_rm, r_s2_sign)) begin
                w_res = r_s2_db ? {r_s2_sign, INF_D[62:0]} : {32'b0, r_s2_sign, INF_S[30:0]};
            end else begin
                w_res = r_s2_db ? {r_s2_sign, MAXF_D[62:0]} : {32'b0, r_s2_sign, MAXF_S[30:0]};
            end
        end else if (w_unf) begin
            w_res = r_s2_db ? {r_s2_sign, 63'b0} : {32'b0, r_s2_sign, 31'b0};
        end
    end

    // Stage valid bits follow the advance chain; reset empties the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            if (w_adv1) r_s1_valid <= bus.in_valid;
            if (w_adv2) r_s2_valid <= r_s1_valid;
            if (w_adv3) r_s3_valid <= r_s2_valid;
        end
    end

    // Stage payloads load alongside their valid bit.
    // NOTE: payloads carry no reset; a beat's data is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r_s1_n    <= w_n;
            r_s1_e    <= w_e1;
            r_s1_sign <= bus.sign;
            r_s1_db   <= bus.db;
            r_s1_rm   <= bus.rm;
        end
        if (w_adv2) begin
            r_s2_frac  <= w_frac;
            r_s2_carry <= w_carry;
            r_s2_e     <= r_s1_e;
            r_s2_sign  <= r_s1_sign;
            r_s2_db    <= r_s1_db;
            r_s2_rm    <= r_s1_rm;
            r_s2_inx   <= w_inx;
        end
    end

    // Output register: result and flags, zeroed for bubbles and on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_inx <= 1'b0;
        end else if (w_adv3) begin
            r_res <= r_s2_valid ? w_res : '0;
            r_ovf <= r_s2_valid & w_ovf;
            r_unf <= r_s2_valid & w_unf;
            r_inx <= r_s2_valid & (r_s2_inx | w_ovf | w_unf);
        end
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.res       = r_res;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.inx       = r_inx;

endmodule
